// File: rtl/branch_arbiter.sv
// rtl/branch_arbiter.sv - two-port round-robin arbiter in front of a shared branch unit
//
// Package branch_arbiter_pkg: operand and result types shared with the branch unit.
//
// Module branch_arbiter: grants one of two branch requesters per cycle to a
// shared combinational branch unit. It registers the result in a single-entry
// response register and stalls after a taken branch until the pipeline flush arrives.
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o       per-requester handshake (N = 0, 1)
//   reqN_instr_type_i, reqN_pc_i,
//   reqN_rs1_i, reqN_rs2_i,
//   reqN_imm_i, reqN_tag_i            per-requester branch operands and ROB tag
//   bu_instr_type_o .. bu_imm_o       operands presented to the branch unit
//   bu_taken_i, bu_result_i,
//   bu_link_pc_i                      same-cycle branch unit results
//   resp_valid_o / resp_ready_i       response handshake
//   resp_port_o, resp_tag_o,
//   resp_link_pc_o                    response payload
//   redirect_valid_o, redirect_pc_o   fetch redirect for a taken response
//   flush_i                           pipeline kill from commit

package branch_arbiter_pkg;

    typedef logic [63:0] addrPC_t;
    typedef logic [63:0] bus64_t;

    typedef enum logic [3:0] {
        INSTR_BEQ  = 4'd0,
        INSTR_BNE  = 4'd1,
        INSTR_BLT  = 4'd2,
        INSTR_BGE  = 4'd3,
        INSTR_BLTU = 4'd4,
        INSTR_BGEU = 4'd5,
        INSTR_JAL  = 4'd6,
        INSTR_JALR = 4'd7
    } instr_type_t;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } branch_decision_t;

endpackage

module branch_arbiter
    import branch_arbiter_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  instr_type_t      req0_instr_type_i,
    input  addrPC_t          req0_pc_i,
    input  bus64_t           req0_rs1_i,
    input  bus64_t           req0_rs2_i,
    input  bus64_t           req0_imm_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  instr_type_t      req1_instr_type_i,
    input  addrPC_t          req1_pc_i,
    input  bus64_t           req1_rs1_i,
    input  bus64_t           req1_rs2_i,
    input  bus64_t           req1_imm_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output instr_type_t      bu_instr_type_o,
    output addrPC_t          bu_pc_o,
    output bus64_t           bu_rs1_o,
    output bus64_t           bu_rs2_o,
    output bus64_t           bu_imm_o,

    input  branch_decision_t bu_taken_i,
    input  addrPC_t          bu_result_i,
    input  addrPC_t          bu_link_pc_i,

    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_port_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output addrPC_t          resp_link_pc_o,

    output logic             redirect_valid_o,
    output addrPC_t          redirect_pc_o,

    input  logic             flush_i
);

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_WAIT_FLUSH = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rr_q;

    logic             resp_valid_q;
    logic             taken_q;
    logic             resp_port_q;
    logic [TAG_W-1:0] resp_tag_q;
    addrPC_t          resp_link_pc_q;
    addrPC_t          redirect_pc_q;

    logic             drain;
    logic             out_free;
    logic             grant_ok;
    logic             grant0;
    logic             grant1;
    logic             grant_any;
    logic             grant_port;

    // Grant qualification and round-robin selection
    always_comb begin
        drain    = resp_valid_q & resp_ready_i;
        out_free = ~resp_valid_q | drain;
        // A taken response leaving this cycle sends us to WAIT_FLUSH, so nothing
        // may follow it into the register; rst_i keeps ready low while asserted.
        grant_ok = ~rst_i & (state_q == ST_RUN) & ~flush_i & out_free
                 & ~(drain & taken_q);
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (grant_ok) begin
            if (rr_q == 1'b0) begin
                if (req0_valid_i) begin
                    grant0 = 1'b1;
                end else if (req1_valid_i) begin
                    grant1 = 1'b1;
                end
            end else begin
                if (req1_valid_i) begin
                    grant1 = 1'b1;
                end else if (req0_valid_i) begin
                    grant0 = 1'b1;
                end
            end
        end
        grant_any  = grant0 | grant1;
        grant_port = grant1;
    end

    // Branch unit operand mux; data is zeroed when idle so the unit sees no stale operands
    always_comb begin
        bu_instr_type_o = rr_q ? req1_instr_type_i : req0_instr_type_i;
        bu_pc_o         = '0;
        bu_rs1_o        = '0;
        bu_rs2_o        = '0;
        bu_imm_o        = '0;
        if (grant0) begin
            bu_instr_type_o = req0_instr_type_i;
            bu_pc_o         = req0_pc_i;
            bu_rs1_o        = req0_rs1_i;
            bu_rs2_o        = req0_rs2_i;
            bu_imm_o        = req0_imm_i;
        end else if (grant1) begin
            bu_instr_type_o = req1_instr_type_i;
            bu_pc_o         = req1_pc_i;
            bu_rs1_o        = req1_rs1_i;
            bu_rs2_o        = req1_rs2_i;
            bu_imm_o        = req1_imm_i;
        end
    end

    // Next-state logic; flush has priority and always returns to RUN
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && drain && taken_q) begin
            state_d = ST_WAIT_FLUSH;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                rr_q <= ~rr_q;
            end
        end
    end

    // Single-entry response register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q   <= 1'b0;
            taken_q        <= 1'b0;
            resp_port_q    <= 1'b0;
            resp_tag_q     <= '0;
            resp_link_pc_q <= '0;
            redirect_pc_q  <= '0;
        end else if (flush_i) begin
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end else if (grant_any) begin
            resp_valid_q   <= 1'b1;
            taken_q        <= (bu_taken_i == TAKEN);
            resp_port_q    <= grant_port;
            resp_tag_q     <= grant_port ? req1_tag_i : req0_tag_i;
            resp_link_pc_q <= bu_link_pc_i;
            redirect_pc_q  <= bu_result_i;
        end else if (drain) begin
            resp_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end
    end

    assign req0_ready_o     = grant0;
    assign req1_ready_o     = grant1;
    assign resp_valid_o     = resp_valid_q;
    assign resp_port_o      = resp_port_q;
    assign resp_tag_o       = resp_tag_q;
    assign resp_link_pc_o   = resp_link_pc_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign redirect_valid_o = resp_valid_q & taken_q;

endmodule

// File: tb/tb_branch_arbiter.sv
// tb/tb_branch_arbiter.sv - directed table-driven bench for branch_arbiter
module tb_branch_arbiter;
    import branch_arbiter_pkg::*;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             v0, v1, r0, r1;
    instr_type_t      t0, t1;
    addrPC_t          pc0, pc1;
    bus64_t           a0, b0, i0, a1, b1, i1;
    logic [TAG_W-1:0] tag0, tag1;
    instr_type_t      bu_t;
    addrPC_t          bu_pc;
    bus64_t           bu_a, bu_b, bu_i;
    branch_decision_t bu_taken;
    addrPC_t          bu_result, bu_link;
    logic             rv, rrdy, rport, redir_v, flush;
    logic [TAG_W-1:0] rtag;
    addrPC_t          rlink, redir_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_arbiter #(.TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_instr_type_i(t0), .req0_pc_i(pc0),
        .req0_rs1_i(a0), .req0_rs2_i(b0), .req0_imm_i(i0), .req0_tag_i(tag0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_instr_type_i(t1), .req1_pc_i(pc1),
        .req1_rs1_i(a1), .req1_rs2_i(b1), .req1_imm_i(i1), .req1_tag_i(tag1),
        .bu_instr_type_o(bu_t), .bu_pc_o(bu_pc), .bu_rs1_o(bu_a), .bu_rs2_o(bu_b),
        .bu_imm_o(bu_i), .bu_taken_i(bu_taken), .bu_result_i(bu_result),
        .bu_link_pc_i(bu_link), .resp_valid_o(rv), .resp_ready_i(rrdy),
        .resp_port_o(rport), .resp_tag_o(rtag), .resp_link_pc_o(rlink),
        .redirect_valid_o(redir_v), .redirect_pc_o(redir_pc), .flush_i(flush)
    );

    // Behavioural branch unit
    always_comb begin
        bu_taken  = NOT_TAKEN;
        bu_result = bu_pc + bu_i;
        bu_link   = bu_pc + 64'd4;
        case (bu_t)
            INSTR_BEQ:  if (bu_a == bu_b) bu_taken = TAKEN;
            INSTR_BNE:  if (bu_a != bu_b) bu_taken = TAKEN;
            INSTR_JAL:  bu_taken = TAKEN;
            INSTR_JALR: begin
                bu_taken  = TAKEN;
                bu_result = (bu_a + bu_i) & ~64'h1;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic             v0, v1;
        instr_type_t      t0, t1;
        logic             rdy, fl;
        logic             er0, er1;
        logic             erv, erp;
        logic [TAG_W-1:0] etag;
        logic             eredir;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic pv0, input logic pv1, input instr_type_t pt0,
                                input instr_type_t pt1, input logic prdy, input logic pfl,
                                input logic per0, input logic per1, input logic perv,
                                input logic perp, input int petag, input logic peredir);
        vec_t v;
        v.v0 = pv0; v.v1 = pv1; v.t0 = pt0; v.t1 = pt1; v.rdy = prdy; v.fl = pfl;
        v.er0 = per0; v.er1 = per1; v.erv = perv; v.erp = perp;
        v.etag = petag[TAG_W-1:0]; v.eredir = peredir;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [63:0] pc, input logic [63:0] rs1, input logic [63:0] imm);
        pc0 = pc; a0 = rs1; b0 = 64'd5; i0 = imm;
        pc1 = pc; a1 = rs1; b1 = 64'd5; i1 = imm;
    endtask

    initial begin
        // index: v0 v1 t0 t1 rdy fl | r0 r1 rv port tag redir
        vecs[0]  = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 1, 0, 1, 0,  0, 0);
        vecs[1]  = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 0, 1, 1, 1,  3, 0);
        vecs[2]  = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 1, 0, 1, 0,  4, 0);
        vecs[3]  = mk(1, 0, INSTR_BNE, INSTR_BNE, 1, 0, 1, 0, 1, 0,  6, 0);
        vecs[4]  = mk(0, 1, INSTR_BNE, INSTR_BNE, 0, 0, 0, 0, 1, 0,  6, 0);
        vecs[5]  = mk(0, 1, INSTR_BNE, INSTR_BNE, 0, 0, 0, 0, 1, 0,  6, 0);
        vecs[6]  = mk(0, 1, INSTR_BNE, INSTR_BNE, 1, 0, 0, 1, 1, 1, 13, 0);
        vecs[7]  = mk(0, 0, INSTR_BNE, INSTR_BNE, 1, 0, 0, 0, 0, 0,  0, 0);
        vecs[8]  = mk(1, 1, INSTR_BEQ, INSTR_BNE, 1, 0, 0, 1, 1, 1, 17, 0);
        vecs[9]  = mk(1, 1, INSTR_BEQ, INSTR_BNE, 1, 0, 1, 0, 1, 0, 18, 1);
        vecs[10] = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 0, 0, 0, 0,  0, 0);
        vecs[11] = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 0, 0, 0, 0,  0, 0);
        vecs[12] = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 1, 0, 0, 0, 0,  0, 0);
        vecs[13] = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 0, 0, 1, 1, 1, 27, 0);
        vecs[14] = mk(1, 1, INSTR_BNE, INSTR_BNE, 0, 1, 0, 0, 0, 0,  0, 0);
        vecs[15] = mk(1, 1, INSTR_BNE, INSTR_BNE, 0, 0, 1, 0, 1, 0, 30, 0);
        vecs[16] = mk(1, 1, INSTR_BNE, INSTR_BNE, 1, 1, 0, 0, 0, 0,  0, 0);

        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; t0 = INSTR_BNE; t1 = INSTR_BNE;
        tag0 = '0; tag1 = '0; rrdy = 1'b1; flush = 1'b0;
        set_ops(64'h1000, 64'd5, 64'h40);

        @(posedge clk); #1;
        chk("reset_resp_valid", {63'd0, rv}, 64'd0);
        chk("reset_redirect_valid", {63'd0, redir_v}, 64'd0);
        chk("reset_ready0", {63'd0, r0}, 64'd0);
        chk("reset_ready1", {63'd0, r1}, 64'd0);
        chk("reset_tag", {58'd0, rtag}, 64'd0);
        chk("reset_link_pc", rlink, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            v0 = vecs[i].v0; v1 = vecs[i].v1; t0 = vecs[i].t0; t1 = vecs[i].t1;
            rrdy = vecs[i].rdy; flush = vecs[i].fl;
            tag0 = 6'(2 * i); tag1 = 6'(2 * i + 1);
            #3;
            chk($sformatf("v%0d_ready0", i), {63'd0, r0}, {63'd0, vecs[i].er0});
            chk($sformatf("v%0d_ready1", i), {63'd0, r1}, {63'd0, vecs[i].er1});
            chk($sformatf("v%0d_bu_rs1", i), bu_a,
                (vecs[i].er0 | vecs[i].er1) ? 64'd5 : 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_resp_valid", i), {63'd0, rv}, {63'd0, vecs[i].erv});
            chk($sformatf("v%0d_redirect_valid", i), {63'd0, redir_v}, {63'd0, vecs[i].eredir});
            if (vecs[i].erv) begin
                chk($sformatf("v%0d_resp_port", i), {63'd0, rport}, {63'd0, vecs[i].erp});
                chk($sformatf("v%0d_resp_tag", i), {58'd0, rtag}, {58'd0, vecs[i].etag});
                chk($sformatf("v%0d_link_pc", i), rlink, 64'h1004);
            end
            if (vecs[i].eredir) begin
                chk($sformatf("v%0d_redirect_pc", i), redir_pc, 64'h1040);
            end
        end

        // JALR: link is pc+4, target has bit 0 cleared
        flush = 1'b0; v1 = 1'b0; v0 = 1'b1; t0 = INSTR_JALR; rrdy = 1'b0;
        pc0 = 64'h3000; a0 = 64'h2001; i0 = 64'd0; tag0 = 6'd40;
        #3;
        chk("jalr_ready0", {63'd0, r0}, 64'd1);
        @(posedge clk); #1;
        chk("jalr_resp_valid", {63'd0, rv}, 64'd1);
        chk("jalr_link_pc", rlink, 64'h3004);
        chk("jalr_redirect_pc", redir_pc, 64'h2000);
        chk("jalr_redirect_valid", {63'd0, redir_v}, 64'd1);
        chk("jalr_tag", {58'd0, rtag}, 64'd40);
        // Accept the taken response, then nothing is granted until flush
        v0 = 1'b0; rrdy = 1'b1;
        @(posedge clk); #1;
        chk("wait_resp_valid", {63'd0, rv}, 64'd0);
        v0 = 1'b1; t0 = INSTR_BNE; set_ops(64'h1000, 64'd5, 64'h40); tag0 = 6'd41;
        #3;
        chk("wait_ready0", {63'd0, r0}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        #3;
        chk("flush_cycle_ready0", {63'd0, r0}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #3;
        chk("post_flush_ready0", {63'd0, r0}, 64'd1);
        @(posedge clk); #1;
        chk("post_flush_tag", {58'd0, rtag}, 64'd41);

        // Asynchronous reset mid-stream
        v0 = 1'b1; v1 = 1'b1; tag0 = 6'd50; tag1 = 6'd51;
        @(posedge clk); #1;
        chk("pre_reset_resp_valid", {63'd0, rv}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_resp_valid", {63'd0, rv}, 64'd0);
        chk("async_reset_redirect_valid", {63'd0, redir_v}, 64'd0);
        chk("async_reset_ready1", {63'd0, r1}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        chk("after_reset_ready0", {63'd0, r0}, 64'd1);
        chk("after_reset_ready1", {63'd0, r1}, 64'd0);
        @(posedge clk); #1;
        chk("after_reset_port", {63'd0, rport}, 64'd0);
        chk("after_reset_tag", {58'd0, rtag}, 64'd50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
